// File: rtl/flappybird_soc_led_blink_pio_if.sv
// ---------------------------------------------------------------------------
// flappybird_soc_led_blink_pio_if
// Register-bus bundle for the LED blink PIO.
//   address    [2:0]  register select
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] combinational read data from the slave
// master: bus initiator, slave: the PIO block.
// ---------------------------------------------------------------------------
interface flappybird_soc_led_blink_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/flappybird_soc_led_blink_pio.sv
// ---------------------------------------------------------------------------
// flappybird_soc_led_blink_pio
// Memory-mapped LED output port with atomic set/clear and an optional
// per-channel blink function.
//
// Parameters
//   WIDTH        number of output channels (1..32)
//   PRESCALE_W   blink period counter width (1..32)
//   RESET_VALUE  reset value of the DATA register
//
// Ports
//   clk       sole clock, rising edge
//   reset     synchronous active-high reset
//   bus       register bus (slave modport)
//   out_port  channel drive, sourced from registers only
//
// Register map
//   0 DATA (RW)   1 BLINK_MASK (RW)   2 PERIOD (RW)   3 STATUS (RO, bit0 phase)
//   4 OUTSET (WO) 5 OUTCLEAR (WO)     6-7 reserved (read 0)
//
// Build option: define LED_PIO_BLINK_EN to include BLINK_MASK, PERIOD,
// STATUS and the blink counter. Without it addresses 1-3 read 0, writes to
// them are ignored and out_port follows DATA directly.
// ---------------------------------------------------------------------------
module flappybird_soc_led_blink_pio #(
    parameter int unsigned      WIDTH       = 14,
    parameter int unsigned      PRESCALE_W  = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    flappybird_soc_led_blink_pio_if.slave         bus,
    output logic [WIDTH-1:0]                      out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [31:0]      rdata;
    logic             unused_wdata;

    logic [WIDTH-1:0] data_q, data_d;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wr_data      = bus.writedata[WIDTH-1:0];
    // Bits above the register widths are intentionally dropped.
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_d = wr_data;
                ADDR_OUTSET:   data_d = data_q | wr_data;
                ADDR_OUTCLEAR: data_d = data_q & ~wr_data;
                default:       data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  phase_q, phase_d;

    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;

        // PERIOD of zero parks the blinker with phase high, so masked
        // channels simply follow DATA.
        if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == period_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end

        if (wr_en) begin
            case (bus.address)
                ADDR_MASK: mask_d = wr_data;
                // A new period restarts the half-period from scratch, which
                // also avoids running cnt up past a smaller new PERIOD.
                ADDR_PERIOD: begin
                    period_d = bus.writedata[PRESCALE_W-1:0];
                    cnt_d    = '0;
                    phase_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    // Masked channels are forced low during the off phase.
    assign out_port = data_q & ~(mask_q & {WIDTH{~phase_q}});
`else
    assign out_port = data_q;
`endif

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:   rdata = 32'(data_q);
`ifdef LED_PIO_BLINK_EN
            ADDR_MASK:   rdata = 32'(mask_q);
            ADDR_PERIOD: rdata = 32'(period_q);
            ADDR_STATUS: rdata = {31'b0, phase_q};
`endif
            default:     rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;

endmodule
